// File: rtl/bit_deserializer.sv
// Serial-to-parallel deserializer: hunts for a SYNC word, then assembles
// FRAME_WORDS data words MSB-first into a one-entry output buffer.
//
// Ports:
//   clk        in   clock, all state changes on posedge
//   rst        in   synchronous active-high reset
//   bit_in     in   serial data bit
//   bit_valid  in   bit_in is sampled only when high
//   out_ready  in   downstream accepts the buffered word this cycle
//   word       out  assembled data word (WIDTH bits)
//   word_valid out  word holds an unconsumed data word
//   locked     out  high while framing data words
//   overflow   out  sticky: a completed word was dropped
module bit_deserializer #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] SYNC        = 8'hA5,
  parameter int               FRAME_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             locked,
  output logic             overflow
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(FRAME_WORDS + 1);

  localparam logic [FW-1:0] FILL_MAX  = FW'(WIDTH);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [CW-1:0] WORD_LAST = CW'(FRAME_WORDS - 1);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]    word_cnt_q, word_cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             word_valid_q, word_valid_d;
  logic             overflow_q, overflow_d;

  logic             offer;
  logic [FW-1:0]    fill_nxt;

  always_comb begin
    state_d      = state_q;
    hist_d       = hist_q;
    fill_d       = fill_q;
    asm_d        = asm_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    overflow_d   = overflow_q;
    offer        = 1'b0;
    fill_nxt     = (fill_q == FILL_MAX) ? FILL_MAX
                                        : fill_q + FW'(1);

    unique case (state_q)
      HUNT: begin
        if (bit_valid) begin
          hist_d = {hist_q[WIDTH-2:0], bit_in};
          fill_d = fill_nxt;
          // fill guard stops stale history from a
          // previous frame matching right after re-entry
          if (hist_d == SYNC && fill_nxt == FILL_MAX) begin
            state_d    = LOCK;
            fill_d     = '0;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
          end
        end
      end
      LOCK: begin
        if (bit_valid) begin
          asm_d = {asm_q[WIDTH-2:0], bit_in};
          if (bit_cnt_q == BIT_LAST) begin
            offer     = 1'b1;
            bit_cnt_d = '0;
            if (word_cnt_q == WORD_LAST) begin
              state_d    = HUNT;
              word_cnt_d = '0;
              fill_d     = '0;
            end else begin
              word_cnt_d = word_cnt_q + CW'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = HUNT;
    endcase

    // One-entry buffer: a word completing on the same edge
    // as a consume replaces the consumed one.
    if (offer) begin
      if (!word_valid_q || out_ready) begin
        word_d       = asm_d;
        word_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (word_valid_q && out_ready) begin
      word_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      hist_q       <= '0;
      fill_q       <= '0;
      asm_q        <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      fill_q       <= fill_d;
      asm_q        <= asm_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign locked     = (state_q == LOCK);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// Scoreboard bench for bit_deserializer: expected words are queued
// when driven and compared when the DUT hands them off.
module tb_bit_deserializer;

  logic       clk;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       out_ready;
  logic [7:0] word;
  logic       word_valid;
  logic       locked;
  logic       overflow;

  int n_chk;
  int n_fail;
  logic [7:0] sb_q[$];

  bit_deserializer #(
    .WIDTH(8),
    .SYNC(8'hA5),
    .FRAME_WORDS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bit_in(bit_in),
    .bit_valid(bit_valid),
    .out_ready(out_ready),
    .word(word),
    .word_valid(word_valid),
    .locked(locked),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every handoff (valid & ready) must match the oldest queued word.
  always @(negedge clk) begin
    if (!rst && word_valid && out_ready) begin
      if (sb_q.size() == 0)
        chk("unexpected_word", {24'h0, word}, 32'hFFFF_FFFF);
      else
        chk("sb_word", {24'h0, word}, {24'h0, sb_q.pop_front()});
    end
  end

  // All drives happen 1 time unit after a posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  // MSB-first; optional idle cycles after bit index 4.
  task automatic send_word(input logic [7:0] w, input int gap);
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i]);
      if (i == 4)
        for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    do_reset();

    chk("rst_word",     {24'h0, word}, 32'h0);
    chk("rst_valid",    {31'h0, word_valid}, 32'h0);
    chk("rst_locked",   {31'h0, locked}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);

    // Sync right after reset release.
    send_word(8'hA5, 0);
    chk("sync_locked", {31'h0, locked}, 32'h1);
    chk("sync_valid",  {31'h0, word_valid}, 32'h0);

    // Word 1 with idle bit cycles in the middle.
    out_ready = 1'b1;
    sb_q.push_back(8'h3C);
    send_word(8'h3C, 3);
    chk("w1_valid", {31'h0, word_valid}, 32'h1);
    chk("w1_word",  {24'h0, word}, 32'h3C);
    tick();
    chk("w1_one_cycle", {31'h0, word_valid}, 32'h0);

    // Words 2,3 with no consumer: second is dropped.
    out_ready = 1'b0;
    sb_q.push_back(8'h11);
    send_word(8'h11, 0);
    send_word(8'h22, 0);
    chk("ovf_word",  {24'h0, word}, 32'h11);
    chk("ovf_valid", {31'h0, word_valid}, 32'h1);
    chk("ovf_flag",  {31'h0, overflow}, 32'h1);
    chk("ovf_locked", {31'h0, locked}, 32'h1);
    out_ready = 1'b1;
    tick();
    chk("ovf_drained", {31'h0, word_valid}, 32'h0);
    chk("ovf_sticky",  {31'h0, overflow}, 32'h1);

    // Word 4 ends the frame.
    sb_q.push_back(8'h5A);
    send_word(8'h5A, 0);
    chk("frame_end_locked", {31'h0, locked}, 32'h0);
    tick();
    send_word(8'hFF, 0);
    tick();
    chk("hunt_no_word",   {31'h0, word_valid}, 32'h0);
    chk("hunt_no_locked", {31'h0, locked}, 32'h0);

    // Completion on the same edge as a consume.
    do_reset();
    send_word(8'hA5, 0);
    out_ready = 1'b0;
    sb_q.push_back(8'h11);
    send_word(8'h11, 0);
    sb_q.push_back(8'h22);
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h22 >> i));
    out_ready = 1'b1;
    send_bit(1'b0);
    chk("bb_valid",    {31'h0, word_valid}, 32'h1);
    chk("bb_word",     {24'h0, word}, 32'h22);
    chk("bb_overflow", {31'h0, overflow}, 32'h0);
    tick();
    chk("bb_drained", {31'h0, word_valid}, 32'h0);

    // Reset mid-word while a word is pending.
    out_ready = 1'b0;
    send_word(8'h33, 0);
    chk("pend_valid", {31'h0, word_valid}, 32'h1);
    for (int i = 7; i >= 3; i--) send_bit(1'(8'h44 >> i));
    rst = 1'b1;
    tick();
    chk("mid_rst_word",     {24'h0, word}, 32'h0);
    chk("mid_rst_valid",    {31'h0, word_valid}, 32'h0);
    chk("mid_rst_locked",   {31'h0, locked}, 32'h0);
    chk("mid_rst_overflow", {31'h0, overflow}, 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    tick();
    chk("post_rst_no_word", {31'h0, word_valid}, 32'h0);

    // Unaligned sync after a fresh reset.
    do_reset();
    send_bit(1'b1);
    send_bit(1'b1);
    send_word(8'hA5, 0);
    chk("unaligned_lock", {31'h0, locked}, 32'h1);
    tick();
    tick();

    chk("sb_empty", sb_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_deserializer.md
BIT_DESERIALIZER -- requirements
Module: bit_deserializer

Interface
REQ-001 Parameter WIDTH, default 8, sets the bits per word and the sync pattern length.
REQ-002 Parameter SYNC, default 8'hA5, is the sync pattern (WIDTH bits) that starts a frame.
REQ-003 Parameter FRAME_WORDS, default 4, is the number of data words per frame after SYNC.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-006 bit_in  input  1  serial data bit, normally driven by the registered q of the upstream D flip-flop.
REQ-007 bit_valid  input  1  bit_in is sampled on a posedge only when bit_valid=1.
REQ-008 out_ready  input  1  downstream accepts the word this cycle.
REQ-009 word  output  WIDTH  assembled data word, MSB-first.
REQ-010 word_valid  output  1  word holds an unconsumed data word.
REQ-011 locked  output  1  high while in LOCK state.
REQ-012 overflow  output  1  sticky flag: a completed word was dropped.

Function
REQ-013 FSM states: HUNT and LOCK only; reset state is HUNT.
REQ-014 HUNT: each sampled bit shifts into a WIDTH-bit history register, new bit entering at LSB.
REQ-015 HUNT: a fill counter counts sampled bits since entering HUNT, saturating at WIDTH.
REQ-016 HUNT->LOCK on the posedge where the history value including the current bit equals SYNC and at least WIDTH bits have been sampled since entering HUNT (including the current bit).
REQ-017 On entering LOCK: bit counter=0, word counter=0, fill counter cleared.
REQ-018 LOCK: each sampled bit shifts into the assembly register MSB-first (first bit ends in word[WIDTH-1]).
REQ-019 LOCK: on the posedge sampling the WIDTH-th bit, the completed word (including that bit) is offered to the output buffer; the bit counter wraps to 0 and the word counter increments.
REQ-020 The output buffer loads the offered word if word_valid=0, or if word_valid=1 and out_ready=1 in the same cycle; word_valid is then 1 from the next cycle (1-cycle latency from the final bit edge).
REQ-021 If word_valid=1 and out_ready=0 when a word is offered, the new word is dropped, word/word_valid stay unchanged, and overflow is set from the next cycle.
REQ-022 Consumed transfer: word_valid & out_ready; with no new word offered, word_valid clears next cycle.
REQ-023 word remains stable while word_valid=1 and out_ready=0.
REQ-024 LOCK->HUNT on the posedge completing word FRAME_WORDS (that word is still offered per REQ-020/021).
REQ-025 Bit cycles with bit_valid=0 change no counters or shift registers; handshake logic still operates.
REQ-026 overflow stays 1 until rst and never clears on its own.
REQ-027 An in-progress partial word is discarded on return to HUNT; no partial word is ever presented.
REQ-028 bit_in=X while sampled is treated as data; no X-detection logic.

Reset
REQ-029 On rst=1 at posedge: state=HUNT, word=0, word_valid=0, locked=0, overflow=0, all counters and shift registers=0.
REQ-030 rst takes priority over all other inputs, including mid-word and mid-handshake; the pending word is lost.
REQ-031 The first posedge with rst=0 may sample a bit.

Verification
REQ-032 rst, then bits 1010_0101 (bit_valid=1) -> locked=1 on the cycle after the 8th bit; word_valid=0.
REQ-033 Locked, out_ready=1, bits 0011_1100 -> word=8'h3C, word_valid=1 exactly one cycle after the 8th bit, for one cycle.
REQ-034 Locked, out_ready=0, two words 8'h11 then 8'h22 -> word holds 8'h11, overflow=1 after the second word completes; raising out_ready consumes 8'h11.
REQ-035 Word completes on the same edge as a consume of the previous word -> new word loaded, word_valid stays 1, overflow=0.
REQ-036 SYNC + 4 words (FRAME_WORDS=4) -> locked drops after the 4th word; later bits 8'hFF produce no word until SYNC is seen again.
REQ-037 rst asserted after 5 bits of a word while word_valid=1 -> next cycle all outputs 0 and state=HUNT; the partial word never appears.
